// File: rtl/buffer_texto.sv
// buffer_texto: capture buffer fed by the PS/2 receive/translate stage.
// Drops key-release sequences (F0 xx) and E0 prefixes. Between a start
// key and a stop key it stores typed characters, with backspace editing,
// in a small RAM that the display stage reads through a registered port.
module buffer_texto #(
    parameter int          PROFUNDIDAD = 32,
    parameter int          AW          = 5,
    parameter logic [6:0]  COD_ESPACIO = 7'h20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dato_listo,
    input  logic [7:0]    datain,
    input  logic [6:0]    traduccion,
    input  logic          validat,
    input  logic          validap,
    input  logic          validab,
    input  logic          iniciar,
    input  logic          terminar,
    input  logic [AW-1:0] rd_addr,
    output logic [6:0]    rd_data,
    output logic [AW:0]   n_chars,
    output logic          capturando,
    output logic          lleno,
    output logic          fin_tick
);

    localparam logic [1:0] ESPERA  = 2'd0;
    localparam logic [1:0] CAPTURA = 2'd1;
    localparam logic [1:0] FIN     = 2'd2;

    localparam logic [AW:0] N_MAX = (AW+1)'(PROFUNDIDAD);
    localparam logic [AW:0] UNO   = (AW+1)'(1);

    logic [1:0]  estado_q, estado_d;
    logic [AW:0] n_chars_q, n_chars_d;
    logic        salta_q, salta_d;
    logic        fin_tick_q, fin_tick_d;
    logic [6:0]  rd_data_q;

    logic        aceptado;
    logic        wr_en;
    logic [6:0]  wr_dato;

    logic [6:0]  mem [PROFUNDIDAD];

    // Byte filter plus capture FSM: decides acceptance, next state, count and write
    always_comb begin
        estado_d   = estado_q;
        n_chars_d  = n_chars_q;
        salta_d    = salta_q;
        fin_tick_d = 1'b0;
        aceptado   = 1'b0;
        wr_en      = 1'b0;
        wr_dato    = traduccion;

        // A byte in reset is never processed, so no write can slip through
        if (reset && dato_listo) begin
            if (datain == 8'hF0) begin
                salta_d = 1'b1;
            end else if (datain == 8'hE0) begin
                salta_d = salta_q;
            end else if (salta_q) begin
                salta_d = 1'b0;            // released key code, discarded
            end else begin
                aceptado = 1'b1;
            end
        end

        if (aceptado) begin
            case (estado_q)
                ESPERA: begin
                    if (iniciar) begin
                        estado_d  = CAPTURA;
                        n_chars_d = '0;
                    end
                end
                CAPTURA: begin
                    if (terminar) begin
                        estado_d   = FIN;
                        fin_tick_d = 1'b1;
                    end else if (iniciar) begin
                        estado_d = CAPTURA;    // start key while capturing is a no-op
                    end else if (validab) begin
                        if (n_chars_q != '0) begin
                            n_chars_d = n_chars_q - UNO;
                        end
                    end else if (validap || validat) begin
                        // A full buffer drops the key and holds the count
                        if (n_chars_q != N_MAX) begin
                            wr_en     = 1'b1;
                            wr_dato   = validap ? COD_ESPACIO : traduccion;
                            n_chars_d = n_chars_q + UNO;
                        end
                    end
                end
                FIN: begin
                    if (iniciar) begin
                        estado_d  = CAPTURA;
                        n_chars_d = '0;
                    end
                end
                default: estado_d = ESPERA;
            endcase
        end
    end

    // Control registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q   <= ESPERA;
            n_chars_q  <= '0;
            salta_q    <= 1'b0;
            fin_tick_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            n_chars_q  <= n_chars_d;
            salta_q    <= salta_d;
            fin_tick_q <= fin_tick_d;
        end
    end

    // Character RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[n_chars_q[AW-1:0]] <= wr_dato;
        end
    end

    // Registered read port; same-edge write to this address returns old data
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data    = rd_data_q;
    assign n_chars    = n_chars_q;
    assign capturando = (estado_q == CAPTURA);
    assign lleno      = (n_chars_q == N_MAX);
    assign fin_tick   = fin_tick_q;

endmodule

// File: tb/tb_buffer_texto.sv
// Testbench for buffer_texto: directed walk through the capture protocol
// followed by randomized key traffic, all checked against a reference model.
module tb_buffer_texto;

    localparam logic [4:0] VT  = 5'b00001;
    localparam logic [4:0] VP  = 5'b00010;
    localparam logic [4:0] VB  = 5'b00100;
    localparam logic [4:0] INI = 5'b01000;
    localparam logic [4:0] TER = 5'b10000;

    logic       clk = 1'b0;
    logic       reset;
    logic       dato_listo;
    logic [7:0] datain;
    logic [6:0] traduccion;
    logic       validat, validap, validab, iniciar, terminar;
    logic [4:0] rd_addr;
    logic [6:0] rd_data;
    logic [5:0] n_chars;
    logic       capturando, lleno, fin_tick;

    int vectores = 0;
    int fallos   = 0;

    // Reference model: 0 = waiting, 1 = capturing, 2 = finished
    int         est_m   = 0;
    int         n_m     = 0;
    bit         salta_m = 0;
    logic [6:0] mem_m   [32];
    bit         known_m [32];
    bit         fin_m   = 0;
    logic [6:0] rd_m    = '0;
    bit         rd_ok_m = 1;

    always #5 clk = ~clk;

    buffer_texto dut (
        .clk        (clk),
        .reset      (reset),
        .dato_listo (dato_listo),
        .datain     (datain),
        .traduccion (traduccion),
        .validat    (validat),
        .validap    (validap),
        .validab    (validab),
        .iniciar    (iniciar),
        .terminar   (terminar),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .n_chars    (n_chars),
        .capturando (capturando),
        .lleno      (lleno),
        .fin_tick   (fin_tick)
    );

    task automatic comprobar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        vectores++;
        if (obs !== esp) begin
            fallos++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Apply the rules of the capture protocol to one clock edge
    task automatic modelo(input logic dl, input logic [7:0] d, input logic [6:0] tr,
                          input logic [4:0] fl, input logic [4:0] ra, input logic rst_n);
        fin_m   = 0;
        rd_m    = mem_m[ra];
        rd_ok_m = known_m[ra];
        if (!rst_n) begin
            est_m = 0; n_m = 0; salta_m = 0; rd_m = '0; rd_ok_m = 1;
        end else if (dl) begin
            if (d == 8'hF0) salta_m = 1;
            else if (d == 8'hE0) salta_m = salta_m;
            else if (salta_m) salta_m = 0;
            else if (est_m != 1) begin
                if (fl[3]) begin est_m = 1; n_m = 0; end
            end else begin
                if (fl[4]) begin est_m = 2; fin_m = 1; end
                else if (fl[3]) est_m = 1;
                else if (fl[2]) begin if (n_m > 0) n_m = n_m - 1; end
                else if ((fl[1] || fl[0]) && n_m < 32) begin
                    mem_m[n_m]   = fl[1] ? 7'h20 : tr;
                    known_m[n_m] = 1;
                    n_m = n_m + 1;
                end
            end
        end
    endtask

    // Caller is at a negedge; drives one cycle, model steps on the edge, check at next negedge
    task automatic aplicar(input logic dl, input logic [7:0] d, input logic [6:0] tr,
                           input logic [4:0] fl, input logic [4:0] ra, input logic rst_n);
        reset = rst_n; dato_listo = dl; datain = d; traduccion = tr;
        {terminar, iniciar, validab, validap, validat} = fl;
        rd_addr = ra;
        @(posedge clk);
        modelo(dl, d, tr, fl, ra, rst_n);
        @(negedge clk);
        comprobar("n_chars", 32'(n_chars), 32'(n_m));
        comprobar("capturando", 32'(capturando), 32'(est_m == 1));
        comprobar("lleno", 32'(lleno), 32'(n_m == 32));
        comprobar("fin_tick", 32'(fin_tick), 32'(fin_m));
        if (rd_ok_m) comprobar("rd_data", 32'(rd_data), 32'(rd_m));
        $display("tx rst=%0b dl=%0b d=%02h tr=%02h fl=%05b | n=%0d cap=%0b full=%0b fin=%0b rd[%0d]=%02h",
                 rst_n, dl, d, tr, fl, n_chars, capturando, lleno, fin_tick, ra, rd_data);
    endtask

    task automatic tecla(input logic [7:0] d, input logic [6:0] tr, input logic [4:0] fl);
        aplicar(1'b1, d, tr, fl, 5'($urandom_range(0, 31)), 1'b1);
    endtask

    task automatic leer(input logic [4:0] ra);
        aplicar(1'b0, 8'h00, 7'h00, 5'b0, ra, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin known_m[i] = 0; mem_m[i] = '0; end
        reset = 1'b0; dato_listo = 1'b0; datain = '0; traduccion = '0;
        validat = 0; validap = 0; validab = 0; iniciar = 0; terminar = 0; rd_addr = '0;

        // Reset state, including rd_data cleared
        aplicar(1'b0, 8'h00, 7'h00, 5'b0, 5'd0, 1'b0);
        aplicar(1'b0, 8'h00, 7'h00, 5'b0, 5'd3, 1'b0);
        comprobar("reset_rd_data", 32'(rd_data), 32'h0);

        // Waiting state ignores printable keys
        tecla(8'h1C, 7'h61, VT);
        tecla(8'h32, 7'h62, VT);
        comprobar("espera_n", 32'(n_chars), 32'h0);
        tecla(8'h5A, 7'h00, INI);
        comprobar("inicio_cap", 32'(capturando), 32'h1);

        // Key press, release sequence, space
        tecla(8'h1C, 7'h61, VT);
        tecla(8'hF0, 7'h00, 5'b0);
        tecla(8'h1C, 7'h61, VT);
        tecla(8'h29, 7'h20, VP);
        comprobar("tras_break_n", 32'(n_chars), 32'h2);
        leer(5'd0);
        comprobar("rd0_a", 32'(rd_data), 32'h61);
        leer(5'd1);
        comprobar("rd1_espacio", 32'(rd_data), 32'h20);

        // Fill past capacity, then backspace once
        for (int i = 0; i < 34; i++) tecla(8'h15 + 8'(i % 8), 7'h41 + 7'(i), VT);
        comprobar("lleno_n", 32'(n_chars), 32'd32);
        comprobar("lleno_flag", 32'(lleno), 32'h1);
        leer(5'd31);
        tecla(8'h66, 7'h08, VB);
        comprobar("bs_n", 32'(n_chars), 32'd31);
        comprobar("bs_lleno", 32'(lleno), 32'h0);

        // Backspace down to zero and one more
        for (int i = 0; i < 32; i++) tecla(8'h66, 7'h08, VB);
        comprobar("bs_cero", 32'(n_chars), 32'h0);

        // E0 prefix: arrow not printable, then one that is
        tecla(8'hE0, 7'h00, 5'b0);
        tecla(8'h75, 7'h00, 5'b0);
        tecla(8'hE0, 7'h00, 5'b0);
        tecla(8'h6B, 7'h34, VT);
        comprobar("e0_n", 32'(n_chars), 32'h1);
        leer(5'd0);
        comprobar("e0_rd", 32'(rd_data), 32'h34);

        // Stop, frozen, restart (back-to-back pulses)
        tecla(8'h76, 7'h00, TER);
        comprobar("fin_pulso", 32'(fin_tick), 32'h1);
        tecla(8'h1C, 7'h61, VT);
        comprobar("fin_baja", 32'(fin_tick), 32'h0);
        comprobar("fin_congelado", 32'(n_chars), 32'h1);
        tecla(8'h5A, 7'h00, INI);
        comprobar("reinicio_n", 32'(n_chars), 32'h0);
        comprobar("reinicio_cap", 32'(capturando), 32'h1);

        // Reset mid-capture with a key present
        tecla(8'h1C, 7'h61, VT);
        tecla(8'h32, 7'h62, VT);
        aplicar(1'b1, 8'h21, 7'h63, VT, 5'd2, 1'b0);
        comprobar("rst_mid_n", 32'(n_chars), 32'h0);
        leer(5'd2);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 99);
            d = 8'($urandom_range(0, 8'hDF));
            if (r < 2)       aplicar(1'b1, d, 7'($urandom), VT, 5'($urandom), 1'b0);
            else if (r < 10) tecla(8'hF0, 7'($urandom), 5'($urandom));
            else if (r < 14) tecla(8'hE0, 7'($urandom), 5'($urandom));
            else if (r < 22) aplicar(1'b0, d, 7'($urandom), 5'($urandom), 5'($urandom), 1'b1);
            else if (r < 28) tecla(d, 7'($urandom), INI);
            else if (r < 31) tecla(d, 7'($urandom), TER);
            else if (r < 40) tecla(d, 7'($urandom), VB);
            else if (r < 50) tecla(d, 7'($urandom), VP);
            else if (r < 60) tecla(d, 7'($urandom), 5'($urandom));
            else             tecla(d, 7'($urandom), VT);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectores, fallos);
        $finish;
    end

endmodule

// File: doc/buffer_texto.md
# buffer_texto

Capture buffer that sits directly downstream of the PS/2 receive/validate/translate stage. It consumes each newly received scan-code byte together with its validation flags and 7-bit translation, and filters out break sequences (F0 xx) and E0 prefixes. Under a start/stop protocol it stores typed characters in a 32-entry buffer, with backspace editing. A registered read port lets the display/transmit stage read the captured text.

## Interface
Parameters:
- PROFUNDIDAD, 32: buffer entries (power of two).
- AW, 5: address width, log2(PROFUNDIDAD).
- COD_ESPACIO, 7'h20: code written for a valid space key.

Ports (name, direction, width, meaning):
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on clk).
- dato_listo  in  1  one-cycle pulse; upstream byte and flags are valid this cycle.
- datain  in  8  raw scan-code byte from the receiver.
- traduccion  in  7  translated character code for datain.
- validat  in  1  datain is a printable key.
- validap  in  1  datain is the space key.
- validab  in  1  datain is backspace.
- iniciar  in  1  datain is the start-capture key.
- terminar  in  1  datain is the stop-capture key.
- rd_addr  in  AW  read address from the display stage.
- rd_data  out  7  buffer contents at rd_addr, registered.
- n_chars  out  AW+1  number of stored characters (0..PROFUNDIDAD).
- capturando  out  1  high while in CAPTURA.
- lleno  out  1  n_chars == PROFUNDIDAD.
- fin_tick  out  1  one-cycle pulse on the CAPTURA->FIN transition.

## Operation
- Byte filter, applied to every dato_listo pulse before the FSM sees it:
  - datain == 8'hF0: set flag `salta`; the byte is not forwarded.
  - datain == 8'hE0: ignored; `salta` is unchanged.
  - Any other byte with `salta` = 1: clear `salta`; the byte is discarded (key release).
  - Otherwise the byte is *accepted*.
- FSM states: ESPERA (reset state), CAPTURA, FIN.
- ESPERA: an accepted byte with iniciar -> CAPTURA; n_chars cleared to 0. All other accepted bytes are ignored.
- CAPTURA, accepted byte, priority high to low:
  - terminar -> FIN, pulse fin_tick.
  - iniciar -> ignored.
  - validab: if n_chars > 0, decrement n_chars; no write. If n_chars == 0, no effect.
  - validap: write COD_ESPACIO at address n_chars, then increment n_chars.
  - validat: write traduccion at address n_chars, then increment n_chars.
- Full buffer: when n_chars == PROFUNDIDAD, writes (validap/validat) are dropped and n_chars holds. Backspace still works.
- FIN: buffer and n_chars are frozen. An accepted iniciar -> CAPTURA with n_chars cleared. Memory contents are not cleared.
- Read port: rd_data <= mem[rd_addr] every cycle, in any state, independent of writes.
- Width rules: n_chars is AW+1 bits and never wraps. Write address is n_chars[AW-1:0], used only when n_chars < PROFUNDIDAD.

## Timing
- Reset (reset = 0 at a clk edge): state = ESPERA, n_chars = 0, salta = 0, capturando = 0, lleno = 0, fin_tick = 0, rd_data = 0. Memory is not cleared.
- Reset has priority over dato_listo in the same cycle. A reset mid-capture returns to ESPERA and discards the count.
- Write/count: the accepting dato_listo edge writes memory, updates n_chars, and updates state. capturando, lleno and n_chars show the new values in the following cycle.
- fin_tick: high exactly one cycle, the cycle after the edge on which terminar is accepted.
- Read latency: 1 cycle, rd_addr sampled at edge N, rd_data valid after edge N. A read of the address being written on the same edge returns the old data.
- dato_listo pulses may arrive on consecutive cycles; each is processed independently with no loss.
- Flags without dato_listo are ignored.

## Test plan
- Reset, then in ESPERA send validat bytes 0x1C, 0x32 -> n_chars = 0, capturando = 0. Send iniciar byte -> capturando = 1 next cycle.
- In CAPTURA, send 0x1C (traduccion 7'h61), F0, 0x1C, 0x29 (space) -> n_chars = 2, rd_addr 0 gives 7'h61, rd_addr 1 gives 7'h20. The released 0x1C is not stored.
- Type 34 valid characters -> n_chars = 32, lleno = 1, entries 32..33 dropped. Backspace once -> n_chars = 31, lleno = 0.
- Backspace with n_chars = 0 -> n_chars stays 0. Send E0 then an arrow code -> stored as a normal byte only if validat.
- Send terminar -> fin_tick high one cycle, state FIN. Further validat bytes leave n_chars unchanged. Send iniciar -> n_chars = 0, capturando = 1.
- Assert reset (0) for one cycle mid-capture with dato_listo = 1 -> ESPERA, n_chars = 0, no write performed.
